// File: rtl/da_pkg.sv
// Shared types and width helpers for the distributed-arithmetic LUT engine.
// Width helpers are constant functions so parameters and ports can use them.
package da_pkg;

    typedef enum logic [2:0] {
        EMPTY,
        BUILD,
        IDLE,
        RUN,
        OUT
    } da_state_e;

    function automatic int lut_depth(input int k);
        return 2 ** (k - 1);
    endfunction

    function automatic int lut_w(input int w, input int k);
        return w + $clog2(k) + 1;
    endfunction

    function automatic int out_w(input int w, input int in_w, input int k);
        return w + in_w + $clog2(k);
    endfunction

endpackage

// File: rtl/da_shared_lut_engine_if.sv
// Weight, operand and result channels of the DA engine, bundled with modports.
// Valid/ready on all three channels: a beat moves on a rising edge where both are high;
// the source keeps valid and data steady until then, and ready may depend on valid.
interface da_shared_lut_engine_if
    import da_pkg::*;
#(
    parameter int K            = 8,
    parameter int DATA_WIDTH_B = 16,
    parameter int IN_WIDTH     = 8,
    parameter int N_CH         = 2
);
    localparam int OUT_W = out_w(DATA_WIDTH_B, IN_WIDTH, K);

    logic                           wt_valid;
    logic                           wt_ready;
    logic [K*DATA_WIDTH_B-1:0]      wt_data;
    logic                           lut_valid;
    logic                           in_valid;
    logic                           in_ready;
    logic [N_CH*K*IN_WIDTH-1:0]     in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [N_CH*OUT_W-1:0]          out_data;

    modport master (
        output wt_valid, wt_data, in_valid, in_data, out_ready,
        input  wt_ready, lut_valid, in_ready, out_valid, out_data
    );

    modport slave (
        input  wt_valid, wt_data, in_valid, in_data, out_ready,
        output wt_ready, lut_valid, in_ready, out_valid, out_data
    );

endinterface

// File: rtl/da_lut_bank.sv
// Offset-binary LUT shared by all channels: weight register, incremental build, and
// folded read ports that recover the upper half of the table by symmetry.
module da_lut_bank
    import da_pkg::*;
#(
    parameter int K          = 8,
    parameter int W          = 16,
    parameter int N_CH       = 2,
    localparam int AW        = K - 1,
    localparam int LUT_W     = lut_w(W, K)
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic [K*W-1:0]          wt_data,
    input  logic                    build_we,
    input  logic [AW-1:0]           build_idx,
    input  logic [N_CH*K-1:0]       rd_addr,
    output logic [N_CH*LUT_W-1:0]   rd_data,
    output logic signed [LUT_W-1:0] l0
);
    localparam int DEPTH = lut_depth(K);

    logic signed [W-1:0]     wt_q [K];
    logic signed [LUT_W-1:0] mem  [DEPTH];
    logic signed [LUT_W-1:0] entry_d;
    logic signed [LUT_W-1:0] lowbit_wt;
    logic [AW-1:0]           parent_idx;

    always_ff @(posedge clk) begin
        if (load) begin
            for (int j = 0; j < K; j++) begin
                wt_q[j] <= wt_data[j*W +: W];
            end
        end
        if (build_we) begin
            mem[build_idx] <= entry_d;
        end
    end

    // Entry i differs from its parent (i with lowest set bit cleared) only in that one tap
    // flipping from -B_p to +B_p; the parent is always written before i.
    always_comb begin
        entry_d    = '0;
        lowbit_wt  = '0;
        parent_idx = build_idx & (build_idx - AW'(1));
        for (int j = K - 2; j >= 0; j--) begin
            if (build_idx[j]) begin
                lowbit_wt = LUT_W'(wt_q[j]);
            end
        end
        if (build_idx == '0) begin
            for (int j = 0; j < K; j++) begin
                entry_d = entry_d - LUT_W'(wt_q[j]);
            end
        end else begin
            entry_d = mem[parent_idx] + (lowbit_wt <<< 1);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_rd
        logic [K-1:0] addr;
        assign addr = rd_addr[c*K +: K];
        // V(d) with top bit set equals -V(~d), so only the lower half is stored.
        assign rd_data[c*LUT_W +: LUT_W] = addr[K-1] ? -mem[~addr[AW-1:0]] : mem[addr[AW-1:0]];
    end

    assign l0 = mem[0];

endmodule

// File: rtl/da_shared_lut_engine.sv
// DA dot-product engine: one shared LUT serves N_CH channels, operands streamed MSB-first
// one bit-plane per cycle, single-entry output register with backpressure.
module da_shared_lut_engine
    import da_pkg::*;
#(
    parameter int K            = 8,
    parameter int DATA_WIDTH_B = 16,
    parameter int IN_WIDTH     = 8,
    parameter int N_CH         = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    da_shared_lut_engine_if.slave    bus,
    output da_state_e                state_dbg
);
    localparam int W     = DATA_WIDTH_B;
    localparam int AW    = K - 1;
    localparam int DEPTH = lut_depth(K);
    localparam int LUT_W = lut_w(W, K);
    localparam int OUT_W = out_w(W, IN_WIDTH, K);
    localparam int ACC_W = OUT_W + 1;
    localparam int CNT_W = (AW > $clog2(IN_WIDTH)) ? AW : $clog2(IN_WIDTH);

    da_state_e                   state_q, state_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [N_CH*K*IN_WIDTH-1:0]  x_q;
    logic signed [ACC_W-1:0]     acc_q [N_CH];
    logic signed [ACC_W-1:0]     acc_d [N_CH];
    logic [N_CH*OUT_W-1:0]       out_q, out_d;
    logic [N_CH*K-1:0]           plane;
    logic [N_CH*LUT_W-1:0]       v_all;
    logic signed [LUT_W-1:0]     l0;
    logic wt_ready_c, in_ready_c, wt_fire, in_fire, build_done, run_done;

    // A pending weight load blocks operands so the new LUT is never mixed with old data.
    assign wt_ready_c = !rst && (state_q == EMPTY || state_q == IDLE);
    assign in_ready_c = !rst && (state_q == IDLE) && !bus.wt_valid;
    assign wt_fire    = bus.wt_valid && wt_ready_c;
    assign in_fire    = bus.in_valid && in_ready_c;
    assign build_done = (cnt_q == CNT_W'(DEPTH - 1));
    assign run_done   = (cnt_q == CNT_W'(IN_WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (wt_fire) state_d = BUILD;
            BUILD:   if (build_done) state_d = IDLE;
            IDLE: begin
                if (wt_fire)      state_d = BUILD;
                else if (in_fire) state_d = RUN;
            end
            RUN:     if (run_done) state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            x_q     <= '0;
            out_q   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            if ((state_q == BUILD || state_q == RUN) && state_d == state_q) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
            if (in_fire) begin
                x_q <= bus.in_data;
            end else if (state_q == RUN) begin
                for (int o = 0; o < N_CH*K; o++) begin
                    x_q[o*IN_WIDTH +: IN_WIDTH] <= {x_q[o*IN_WIDTH +: IN_WIDTH-1], 1'b0};
                end
            end
            if (state_q == RUN) begin
                for (int c = 0; c < N_CH; c++) begin
                    acc_q[c] <= acc_d[c];
                end
                if (run_done) begin
                    out_q <= out_d;
                end
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic signed [LUT_W-1:0] v;
        logic signed [ACC_W-1:0] sum;
        for (genvar j = 0; j < K; j++) begin : g_bit
            assign plane[c*K+j] = x_q[(c*K+j)*IN_WIDTH + IN_WIDTH - 1];
        end
        assign v        = v_all[c*LUT_W +: LUT_W];
        // The sign plane carries negative weight; later planes are Horner-accumulated.
        assign acc_d[c] = (cnt_q == '0) ? -ACC_W'(v) : (acc_q[c] <<< 1) + ACC_W'(v);
        assign sum      = acc_d[c] + ACC_W'(l0);
        assign out_d[c*OUT_W +: OUT_W] = OUT_W'(sum >>> 1);
    end

    da_lut_bank #(
        .K    (K),
        .W    (W),
        .N_CH (N_CH)
    ) u_bank (
        .clk       (clk),
        .load      (wt_fire),
        .wt_data   (bus.wt_data),
        .build_we  (state_q == BUILD),
        .build_idx (cnt_q[AW-1:0]),
        .rd_addr   (plane),
        .rd_data   (v_all),
        .l0        (l0)
    );

    assign bus.wt_ready  = wt_ready_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.lut_valid = state_q inside {IDLE, RUN, OUT};
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_q;
    assign state_dbg     = state_q;

endmodule
